// File: rtl/wb_commit_ss_pkg.sv
// Shared constants for the dual-lane writeback commit and pending-write scoreboard.
package wb_commit_ss_pkg;

  localparam int unsigned NREG  = 32;
  localparam int unsigned DATAW = 32;
  localparam int unsigned CNTW  = 2;
  localparam int unsigned REGW  = 5;

  localparam logic [REGW-1:0] ZERO_REG = '0;

endpackage

// File: rtl/wb_commit_ss_pend_cnt.sv
// One per-register pending-write counter: up/down by 0..2 per cycle, floors at 0,
// async reset and synchronous clear.
module pend_cnt #(
  parameter int unsigned Width = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [1:0]       inc,
  input  logic [1:0]       dec,
  output logic [Width-1:0] cnt
);

  localparam logic [Width+1:0] MaxCnt = (Width+2)'((1 << Width) - 1);

  logic [Width-1:0] cnt_d, cnt_q;
  logic [Width+1:0] sum;
  logic [Width+1:0] dec_w;
  logic [Width+1:0] diff;

  always_comb begin
    sum   = {2'b00, cnt_q} + {{Width{1'b0}}, inc};
    dec_w = {{Width{1'b0}}, dec};
    diff  = sum - dec_w;
    if (clr) begin
      cnt_d = '0;
    end else if (sum <= dec_w) begin
      // Extra decrements on an empty counter are dropped rather than wrapping.
      cnt_d = '0;
    end else if (diff > MaxCnt) begin
      cnt_d = MaxCnt[Width-1:0];
    end else begin
      cnt_d = diff[Width-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/wb_commit_ss.sv
// Dual-lane writeback commit stage with per-register pending-write counters,
// issue stall on counter overflow and per-source ready flags for decode.
module wb_commit_ss #(
  parameter int unsigned NREG  = wb_commit_ss_pkg::NREG,
  parameter int unsigned DATAW = wb_commit_ss_pkg::DATAW,
  parameter int unsigned CNTW  = wb_commit_ss_pkg::CNTW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             iss_valid_1,
  input  logic             iss_valid_2,
  input  logic             iss_wr_1,
  input  logic             iss_wr_2,
  input  logic [4:0]       iss_dst_1,
  input  logic [4:0]       iss_dst_2,
  output logic             iss_stall,
  input  logic             wb_valid_1,
  input  logic             wb_valid_2,
  input  logic             wb_regwrite_1,
  input  logic             wb_regwrite_2,
  input  logic [4:0]       wb_dst_1,
  input  logic [4:0]       wb_dst_2,
  input  logic [DATAW-1:0] wb_data_1,
  input  logic [DATAW-1:0] wb_data_2,
  output logic             we3_1,
  output logic             we3_2,
  output logic [4:0]       wa3_1,
  output logic [4:0]       wa3_2,
  output logic [DATAW-1:0] wd3_1,
  output logic [DATAW-1:0] wd3_2,
  input  logic [4:0]       src_1,
  input  logic [4:0]       src_2,
  input  logic [4:0]       src_3,
  input  logic [4:0]       src_4,
  output logic [3:0]       src_rdy
);

  import wb_commit_ss_pkg::*;

  localparam int MaxCnt = (1 << CNTW) - 1;

  logic            commit_1, commit_2;
  logic            iss_req_1, iss_req_2;
  logic            iss_go_1, iss_go_2;
  int              proj_1, proj_2;
  logic [CNTW-1:0] pend [NREG];
  logic [REGW-1:0] src [4];

  // Commit and issue qualification
  always_comb begin
    commit_1  = wb_valid_1 & wb_regwrite_1 & (wb_dst_1 != ZERO_REG);
    commit_2  = wb_valid_2 & wb_regwrite_2 & (wb_dst_2 != ZERO_REG);
    iss_req_1 = iss_valid_1 & iss_wr_1 & (iss_dst_1 != ZERO_REG);
    iss_req_2 = iss_valid_2 & iss_wr_2 & (iss_dst_2 != ZERO_REG);
    iss_go_1  = iss_req_1 & ~iss_stall & ~flush;
    iss_go_2  = iss_req_2 & ~iss_stall & ~flush;
  end

  // Projected count per issuing destination, net of this cycle's commits.
  always_comb begin
    proj_1 = int'(pend[iss_dst_1]) + 1
           + int'(iss_req_2 && (iss_dst_2 == iss_dst_1))
           - int'(commit_1 && (wb_dst_1 == iss_dst_1))
           - int'(commit_2 && (wb_dst_2 == iss_dst_1));
    proj_2 = int'(pend[iss_dst_2]) + 1
           + int'(iss_req_1 && (iss_dst_1 == iss_dst_2))
           - int'(commit_1 && (wb_dst_1 == iss_dst_2))
           - int'(commit_2 && (wb_dst_2 == iss_dst_2));
    iss_stall = (iss_req_1 && (proj_1 > MaxCnt)) || (iss_req_2 && (proj_2 > MaxCnt));
  end

  assign pend[0] = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    logic [1:0] inc, dec;

    assign inc = 2'(iss_go_1 && (iss_dst_1 == REGW'(r)))
               + 2'(iss_go_2 && (iss_dst_2 == REGW'(r)));
    // A lane-1 commit that loses the write-port conflict still retires its pending write.
    assign dec = 2'(commit_1 && (wb_dst_1 == REGW'(r)))
               + 2'(commit_2 && (wb_dst_2 == REGW'(r)));

    pend_cnt #(
      .Width (CNTW)
    ) u_pend_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (flush),
      .inc   (inc),
      .dec   (dec),
      .cnt   (pend[r])
    );
  end

  assign src[0] = src_1;
  assign src[1] = src_2;
  assign src[2] = src_3;
  assign src[3] = src_4;

  for (genvar k = 0; k < 4; k++) begin : g_rdy
    assign src_rdy[k] = (src[k] == ZERO_REG) || (pend[src[k]] == '0);
  end

  // Registered register-file write port
  logic             we3_1_d, we3_1_q, we3_2_d, we3_2_q;
  logic [4:0]       wa3_1_d, wa3_1_q, wa3_2_d, wa3_2_q;
  logic [DATAW-1:0] wd3_1_d, wd3_1_q, wd3_2_d, wd3_2_q;

  always_comb begin
    we3_1_d = commit_1 & ~(commit_2 & (wb_dst_1 == wb_dst_2));
    we3_2_d = commit_2;
    wa3_1_d = wb_dst_1;
    wa3_2_d = wb_dst_2;
    wd3_1_d = wb_data_1;
    wd3_2_d = wb_data_2;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we3_1_q <= 1'b0;
      we3_2_q <= 1'b0;
      wa3_1_q <= '0;
      wa3_2_q <= '0;
      wd3_1_q <= '0;
      wd3_2_q <= '0;
    end else begin
      we3_1_q <= we3_1_d;
      we3_2_q <= we3_2_d;
      wa3_1_q <= wa3_1_d;
      wa3_2_q <= wa3_2_d;
      wd3_1_q <= wd3_1_d;
      wd3_2_q <= wd3_2_d;
    end
  end

  assign we3_1 = we3_1_q;
  assign we3_2 = we3_2_q;
  assign wa3_1 = wa3_1_q;
  assign wa3_2 = wa3_2_q;
  assign wd3_1 = wd3_1_q;
  assign wd3_2 = wd3_2_q;

endmodule

// File: tb/tb_wb_commit_ss.sv
// Directed bench for wb_commit_ss: write-port results go through a scoreboard queue,
// pending-counter effects are observed through src_rdy and iss_stall.
module tb_wb_commit_ss;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        iss_valid_1, iss_valid_2, iss_wr_1, iss_wr_2;
  logic [4:0]  iss_dst_1, iss_dst_2;
  logic        iss_stall;
  logic        wb_valid_1, wb_valid_2, wb_regwrite_1, wb_regwrite_2;
  logic [4:0]  wb_dst_1, wb_dst_2;
  logic [31:0] wb_data_1, wb_data_2;
  logic        we3_1, we3_2;
  logic [4:0]  wa3_1, wa3_2;
  logic [31:0] wd3_1, wd3_2;
  logic [4:0]  src_1, src_2, src_3, src_4;
  logic [3:0]  src_rdy;

  wb_commit_ss dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .iss_valid_1   (iss_valid_1),
    .iss_valid_2   (iss_valid_2),
    .iss_wr_1      (iss_wr_1),
    .iss_wr_2      (iss_wr_2),
    .iss_dst_1     (iss_dst_1),
    .iss_dst_2     (iss_dst_2),
    .iss_stall     (iss_stall),
    .wb_valid_1    (wb_valid_1),
    .wb_valid_2    (wb_valid_2),
    .wb_regwrite_1 (wb_regwrite_1),
    .wb_regwrite_2 (wb_regwrite_2),
    .wb_dst_1      (wb_dst_1),
    .wb_dst_2      (wb_dst_2),
    .wb_data_1     (wb_data_1),
    .wb_data_2     (wb_data_2),
    .we3_1         (we3_1),
    .we3_2         (we3_2),
    .wa3_1         (wa3_1),
    .wa3_2         (wa3_2),
    .wd3_1         (wd3_1),
    .wd3_2         (wd3_2),
    .src_1         (src_1),
    .src_2         (src_2),
    .src_3         (src_3),
    .src_4         (src_4),
    .src_rdy       (src_rdy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        we2;
    logic [4:0]  wa2;
    logic [31:0] wd2;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    flush = 1'b0;
    iss_valid_1 = 1'b0; iss_valid_2 = 1'b0; iss_wr_1 = 1'b0; iss_wr_2 = 1'b0;
    iss_dst_1 = '0; iss_dst_2 = '0;
    wb_valid_1 = 1'b0; wb_valid_2 = 1'b0; wb_regwrite_1 = 1'b0; wb_regwrite_2 = 1'b0;
    wb_dst_1 = '0; wb_dst_2 = '0; wb_data_1 = '0; wb_data_2 = '0;
  endtask

  task automatic issue(input logic v1, input logic [4:0] d1, input logic v2, input logic [4:0] d2);
    iss_valid_1 = v1; iss_wr_1 = v1; iss_dst_1 = d1;
    iss_valid_2 = v2; iss_wr_2 = v2; iss_dst_2 = d2;
  endtask

  task automatic commit(input logic v1, input logic [4:0] d1, input logic [31:0] x1,
                        input logic v2, input logic [4:0] d2, input logic [31:0] x2);
    wb_valid_1 = v1; wb_regwrite_1 = v1; wb_dst_1 = d1; wb_data_1 = x1;
    wb_valid_2 = v2; wb_regwrite_2 = v2; wb_dst_2 = d2; wb_data_2 = x2;
  endtask

  // Push the expected write-port result for the coming edge, clock, then pop and compare.
  task automatic cycle(input string tag);
    wr_t  want, got;
    logic c1, c2;
    c1 = wb_valid_1 && wb_regwrite_1 && (wb_dst_1 != 5'd0);
    c2 = wb_valid_2 && wb_regwrite_2 && (wb_dst_2 != 5'd0);
    want = '0;
    if (!reset) begin
      want.we1 = c1 && !(c2 && (wb_dst_1 == wb_dst_2));
      want.wa1 = wb_dst_1;
      want.wd1 = wb_data_1;
      want.we2 = c2;
      want.wa2 = wb_dst_2;
      want.wd2 = wb_data_2;
    end
    sb.push_back(want);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({tag, ".we3_1"}, 32'(we3_1), 32'(got.we1));
    chk({tag, ".we3_2"}, 32'(we3_2), 32'(got.we2));
    if (got.we1) begin
      chk({tag, ".wa3_1"}, 32'(wa3_1), 32'(got.wa1));
      chk({tag, ".wd3_1"}, wd3_1, got.wd1);
    end
    if (got.we2) begin
      chk({tag, ".wa3_2"}, 32'(wa3_2), 32'(got.wa2));
      chk({tag, ".wd3_2"}, wd3_2, got.wd2);
    end
  endtask

  initial begin
    idle();
    src_1 = 5'd0; src_2 = 5'd0; src_3 = 5'd0; src_4 = 5'd0;
    reset = 1'b1;
    #1;
    chk("rst.src_rdy", 32'(src_rdy), 32'hf);
    chk("rst.stall", 32'(iss_stall), 32'h0);
    chk("rst.we3_1", 32'(we3_1), 32'h0);
    chk("rst.we3_2", 32'(we3_2), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    cycle("idle");

    // Issue lane 1 to r5, commit it two cycles later.
    src_1 = 5'd5;
    issue(1'b1, 5'd5, 1'b0, 5'd0);
    cycle("iss5");
    idle();
    #1 chk("r5.pending_a", 32'(src_rdy), 32'he);
    cycle("wait5");
    commit(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    #1 chk("r5.no_fwd", 32'(src_rdy), 32'he);
    cycle("wb5");
    idle();
    #1 chk("r5.ready", 32'(src_rdy), 32'hf);

    // Both lanes pending and committing r7: younger lane wins, count drops by 2.
    src_1 = 5'd7;
    issue(1'b1, 5'd7, 1'b1, 5'd7);
    cycle("iss7");
    idle();
    #1 chk("r7.pending", 32'(src_rdy), 32'he);
    commit(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22);
    cycle("wb7");
    idle();
    #1 chk("r7.drop2", 32'(src_rdy), 32'hf);

    // Four increments to r9: the second pair stalls and is not counted.
    src_1 = 5'd9;
    issue(1'b1, 5'd9, 1'b1, 5'd9);
    #1 chk("r9.stall_a", 32'(iss_stall), 32'h0);
    cycle("iss9a");
    #1 chk("r9.stall_b", 32'(iss_stall), 32'h1);
    cycle("iss9b");
    idle();
    #1 chk("r9.stall_c", 32'(iss_stall), 32'h0);
    commit(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0);
    cycle("wb9a");
    idle();
    #1 chk("r9.left1", 32'(src_rdy), 32'he);
    commit(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h9999);
    cycle("wb9b");
    idle();
    #1 chk("r9.empty", 32'(src_rdy), 32'hf);

    // Destination 0 never writes.
    commit(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'hFFFFFFFF);
    cycle("wb0");
    idle();
    #1 chk("r0.rdy", 32'(src_rdy), 32'hf);

    // pend[3]=2, then flush with an issue to r3; flush still lets r12's write out.
    src_1 = 5'd3;
    issue(1'b1, 5'd3, 1'b1, 5'd3);
    cycle("iss3");
    idle();
    #1 chk("r3.pending", 32'(src_rdy), 32'he);
    flush = 1'b1;
    issue(1'b1, 5'd3, 1'b0, 5'd0);
    commit(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hA5A5A5A5);
    cycle("flush");
    idle();
    #1 chk("r3.flushed", 32'(src_rdy), 32'hf);

    // Leave r4 pending and a we3_2 pulse live, then reset between edges.
    src_4 = 5'd4;
    issue(1'b1, 5'd4, 1'b0, 5'd0);
    commit(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'h5A5A5A5A);
    cycle("pre_rst");
    issue(1'b0, 5'd0, 1'b0, 5'd0);
    #1 chk("r4.pending", 32'(src_rdy), 32'h7);
    #1 reset = 1'b1;
    #1;
    chk("arst.we3_2", 32'(we3_2), 32'h0);
    chk("arst.src_rdy", 32'(src_rdy), 32'hf);
    chk("arst.stall", 32'(iss_stall), 32'h0);
    cycle("rst_hold");
    reset = 1'b0;
    idle();
    cycle("post_rst");
    chk("sb.empty", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_commit_ss.md
WB_COMMIT_SS -- requirements
Module: wb_commit_ss

Interface
REQ-001 Parameters SHALL be: NREG=32, register count; DATAW=32, data width; CNTW=2, pending-counter width.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, the single clock; all state changes on its rising edge.
- reset, in, 1, asynchronous, active-high.
- flush, in, 1, synchronous pipeline flush.
- iss_valid_1 / iss_valid_2, in, 1 each, lane 1 / lane 2 instruction issues this cycle.
- iss_wr_1 / iss_wr_2, in, 1 each, issuing instruction writes a register.
- iss_dst_1 / iss_dst_2, in, 5 each, issuing destination.
- iss_stall, out, 1, issue blocked because a counter would overflow.
- wb_valid_1 / wb_valid_2, in, 1 each, lane 1 (older) / lane 2 (younger) at writeback.
- wb_regwrite_1 / wb_regwrite_2, in, 1 each, writeback writes a register.
- wb_dst_1 / wb_dst_2, in, 5 each, writeback destination.
- wb_data_1 / wb_data_2, in, 32 each, writeback result.
- we3_1 / we3_2, out, 1 each, register-file write enables.
- wa3_1 / wa3_2, out, 5 each, register-file write addresses.
- wd3_1 / wd3_2, out, 32 each, register-file write data.
- src_1 .. src_4, in, 5 each, decode source fields: lane-1 rs, lane-1 rt, lane-2 rs, lane-2 rt.
- src_rdy, out, 4, bit k set when src_(k+1) has no pending write.

Function
REQ-003 Commit term: lane n SHALL commit when wb_valid_n & wb_regwrite_n & (wb_dst_n != 0).
REQ-004 Write outputs SHALL be registered with 1-cycle latency: we3_n/wa3_n/wd3_n show the commit sampled on the previous edge.
REQ-005 Destination 0 SHALL never produce we3_n=1.
REQ-006 Same-cycle conflict: when both lanes commit with wb_dst_1 == wb_dst_2, we3_1 SHALL be 0 and we3_2 SHALL be 1, so the younger lane wins.
REQ-007 Each register r SHALL have a pending counter pend[r], 0..3.
REQ-008 Counter increment: +1 per lane with iss_valid_n & iss_wr_n & (iss_dst_n != 0) & !iss_stall & !flush; two lanes issuing the same dst give +2.
REQ-009 Counter decrement: -1 per committing lane, including a lane-1 commit suppressed by REQ-006; two lanes committing the same dst give -2.
REQ-010 Simultaneous issue and commit to one register SHALL apply the net delta in one cycle.
REQ-011 iss_stall SHALL be combinational and SHALL be 1 when pend[d] + (issue increments to d) - (commit decrements to d) > 3 for any issuing d.
REQ-012 When iss_stall=1, neither lane's issue SHALL be counted.
REQ-013 Decrementing a counter already at 0 SHALL leave it at 0 and never wrap.
REQ-014 src_rdy[k] SHALL be combinational from the registered counters: 1 if src == 0 or pend[src] == 0.
REQ-015 src_rdy SHALL not forward a same-cycle commit.
REQ-016 flush=1 SHALL zero all counters on the next edge and ignore that cycle's issues and commits for counting.
REQ-017 flush=1 SHALL NOT squash that cycle's write outputs.

Reset
REQ-018 reset=1 SHALL immediately, without waiting for a clock edge, force all counters to 0, we3_1/we3_2 to 0, wa3_n to 0, and wd3_n to 0.
REQ-019 Consequently, after reset src_rdy SHALL be 4'b1111 and iss_stall SHALL be 0.
REQ-020 Reset asserted mid-operation SHALL discard in-flight writes, so no we3 pulse occurs for the cycle the reset is held.

Structure
REQ-021 A shared package SHALL hold NREG, DATAW, CNTW, the register-address width (5), and the constant ZERO_REG=0.
REQ-022 Sub-module pend_cnt SHALL implement one saturating-at-0, 2-bit, up/down-by-0..2 counter with async reset and sync clear; it SHALL be instantiated NREG-1 times, and r0 SHALL be tied to 0.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Issue lane 1 dst=5, commit lane 1 dst=5 data=0xDEADBEEF two cycles later -> src_rdy for rs=5 is 0 until the commit edge; next cycle we3_1=1, wa3_1=5, wd3_1=0xDEADBEEF; then src_rdy=1.
- Both lanes commit dst=7, data 0x11 (lane 1) and 0x22 (lane 2) -> we3_1=0, we3_2=1, wd3_2=0x22; pend[7] drops by 2.
- Issue dst=9 on both lanes twice (4 increments) -> second pair raises iss_stall=1 and pend[9] stays 2.
- Commit dst=0 with data 0xFFFFFFFF -> we3_1=0 and we3_2=0; no counter changes.
- pend[3]=2, then flush with a simultaneous issue to dst 3 -> pend[3]=0 next cycle and src_rdy for 3 is 1.
- Assert reset between clock edges with we3_2=1 -> we3_2 falls immediately and all src_rdy bits read 1.
